// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the cartridge ROM loader: bank-switch codes,
// loader states, ASCII extension constants, size thresholds and lookup helpers.
package rom_loader_pkg;

  typedef enum logic [3:0] {
    BS_NONE = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  localparam logic [23:0] EXT_F8 = 24'h2E4638;
  localparam logic [23:0] EXT_F6 = 24'h2E4636;
  localparam logic [23:0] EXT_FE = 24'h2E4645;
  localparam logic [23:0] EXT_E0 = 24'h2E4530;
  localparam logic [23:0] EXT_3F = 24'h2E3346;
  localparam logic [23:0] EXT_F4 = 24'h2E4634;
  localparam logic [23:0] EXT_P2 = 24'h2E5032;
  localparam logic [23:0] EXT_FA = 24'h2E4641;
  localparam logic [23:0] EXT_CV = 24'h2E4356;

  localparam logic [7:0] ASCII_DOT = 8'h2E;
  localparam logic [7:0] ASCII_S   = 8'h53;

  localparam int unsigned SZ_4K  = 4096;
  localparam int unsigned SZ_8K  = 8192;
  localparam int unsigned SZ_12K = 12288;
  localparam int unsigned SZ_16K = 16384;
  localparam int unsigned SZ_32K = 32768;

  // STA $3F opcode/operand pair that marks Tigervision-style bank switching
  localparam logic [7:0] SIG_STA = 8'h85;
  localparam logic [7:0] SIG_ZP  = 8'h3F;

  function automatic bs_e bs_from_ext(input logic [23:0] ext);
    bs_e r;
    case (ext)
      EXT_F8:  r = BS_F8;
      EXT_F6:  r = BS_F6;
      EXT_FE:  r = BS_FE;
      EXT_E0:  r = BS_E0;
      EXT_3F:  r = BS_3F;
      EXT_F4:  r = BS_F4;
      EXT_P2:  r = BS_P2;
      EXT_FA:  r = BS_FA;
      EXT_CV:  r = BS_CV;
      default: r = BS_NONE;
    endcase
    return r;
  endfunction

  function automatic bs_e bs_from_size(input int unsigned sz);
    bs_e r;
    case (sz)
      SZ_8K:   r = BS_F8;
      SZ_12K:  r = BS_FA;
      SZ_16K:  r = BS_F6;
      SZ_32K:  r = BS_F4;
      default: r = BS_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rom_loader_bs_sig_scan.sv
// Content scan over the download stream: SuperChip fill heuristic and a
// saturating count of consecutive 0x85,0x3F byte pairs.
module rom_sig_scan
  import rom_loader_pkg::*;
#(
  parameter int AW          = 15,
  parameter int SC_SCAN_LEN = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i,
  output logic          scflag_o,
  output logic [2:0]    sig_cnt_o
);

  localparam logic [AW:0] SCAN_LEN_W = (AW+1)'(SC_SCAN_LEN);

  logic [7:0] byte0_q;
  logic [7:0] prev_q;
  logic       prev_vld_q;
  logic       scflag_q;
  logic [2:0] sig_q;

  logic in_window;
  logic pair_hit;

  assign in_window = ({1'b0, addr_i} < SCAN_LEN_W);
  assign pair_hit  = prev_vld_q && (prev_q == SIG_STA) && (data_i == SIG_ZP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte0_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      scflag_q   <= 1'b0;
      sig_q      <= '0;
    end else if (clr_i) begin
      byte0_q    <= '0;
      prev_vld_q <= 1'b0;
      scflag_q   <= 1'b1;
      sig_q      <= '0;
    end else if (wr_i) begin
      prev_q     <= data_i;
      prev_vld_q <= 1'b1;
      if (pair_hit && (sig_q != 3'd7)) sig_q <= sig_q + 3'd1;
      // Address 0 sets the reference; any differing early byte kills the flag
      if (addr_i == '0) byte0_q <= data_i;
      else if (in_window && (data_i != byte0_q)) scflag_q <= 1'b0;
    end
  end

  assign scflag_o  = scflag_q;
  assign sig_cnt_o = sig_q;

endmodule

// File: rtl/rom_loader_bs.sv
// Forwards ioctl download bytes into the cartridge ROM RAM, tracks image size and
// resolves bank-switch code / SuperChip enable at end of download. Content scan
// heuristics are compiled in with BS_SIGSCAN_EN.
module rom_loader_bs
  import rom_loader_pkg::*;
#(
  parameter int AW          = 15,
  parameter int SZW         = 17,
  parameter int SC_SCAN_LEN = 256
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           ioctl_download,
  input  logic           ioctl_wr,
  input  logic [24:0]    ioctl_addr,
  input  logic [7:0]     ioctl_dout,
  input  logic [31:0]    ioctl_file_ext,
  input  logic [1:0]     sc_mode,
  output logic           rom_we,
  output logic [AW-1:0]  rom_waddr,
  output logic [7:0]     rom_wdata,
  output logic [SZW-1:0] rom_size,
  output logic [3:0]     force_bs,
  output logic           sc,
  output logic           loading,
  output logic           done
);

  localparam logic [25:0] SIZE_MAX = 26'((64'd1 << SZW) - 64'd1);

  state_e         state_q;
  logic           dl_q;
  logic           rise_pend_q;
  logic [23:0]    ext_q;
  logic           sflag_q;
  logic           rom_we_q;
  logic [AW-1:0]  waddr_q;
  logic [7:0]     wdata_q;
  logic [SZW-1:0] size_q;
  bs_e            bs_q;
  logic           sc_q;
  logic           loading_q;
  logic           done_q;

  logic           rise;
  logic           fall;
  logic           load_start;
  logic           wr_load;
  logic           in_range;
  logic [25:0]    addr_p1;
  logic [SZW-1:0] size_cand;
  bs_e            bs_d;
  logic           sc_d;
  logic           sc_auto;

  assign rise       = ioctl_download & ~dl_q;
  assign fall       = ~ioctl_download & dl_q;
  assign load_start = (state_q == ST_IDLE) && (rise || rise_pend_q);
  assign wr_load    = (state_q == ST_LOAD) && ioctl_wr;
  assign in_range   = (ioctl_addr[24:AW] == '0);
  assign addr_p1    = {1'b0, ioctl_addr} + 26'd1;
  assign size_cand  = (addr_p1 > SIZE_MAX) ? SIZE_MAX[SZW-1:0] : addr_p1[SZW-1:0];

`ifdef BS_SIGSCAN_EN
  logic       scan_flag;
  logic [2:0] sig_cnt;

  rom_sig_scan #(
    .AW          (AW),
    .SC_SCAN_LEN (SC_SCAN_LEN)
  ) u_sig_scan (
    .clk_i     (clk_sys),
    .rst_ni    (reset_n),
    .clr_i     (load_start),
    .wr_i      (wr_load && in_range),
    .addr_i    (ioctl_addr[AW-1:0]),
    .data_i    (ioctl_dout),
    .scflag_o  (scan_flag),
    .sig_cnt_o (sig_cnt)
  );
`endif

  always_comb begin
    bs_d    = bs_from_ext(ext_q);
    sc_auto = sflag_q;
`ifdef BS_SIGSCAN_EN
    // Content rules only break ties when the extension says nothing
    if (bs_d == BS_NONE) begin
      if ((sig_cnt >= 3'd2) && (32'(size_q) > SZ_4K)) bs_d = BS_3F;
      else bs_d = bs_from_size(32'(size_q));
    end
    sc_auto = sflag_q | scan_flag;
`endif
    sc_d = (sc_mode == 2'd0) ? sc_auto : sc_mode[1];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dl_q        <= 1'b1;  // a download already high at release is not an edge
      rise_pend_q <= 1'b0;
      ext_q       <= '0;
      sflag_q     <= 1'b0;
      rom_we_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      bs_q        <= BS_NONE;
      sc_q        <= 1'b0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      rom_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q     <= ST_LOAD;
            loading_q   <= 1'b1;
            rise_pend_q <= 1'b0;
            ext_q       <= (ioctl_file_ext[23:16] == ASCII_DOT) ? ioctl_file_ext[23:0]
                                                                : ioctl_file_ext[31:8];
            sflag_q     <= (ioctl_file_ext[7:0] == ASCII_S);
            size_q      <= '0;
          end
        end
        ST_LOAD: begin
          if (ioctl_wr) begin
            rom_we_q <= in_range;
            if (in_range) begin
              waddr_q <= ioctl_addr[AW-1:0];
              wdata_q <= ioctl_dout;
            end
            if (size_cand > size_q) size_q <= size_cand;
          end
          if (fall) begin
            state_q   <= ST_RESOLVE;
            loading_q <= 1'b0;
          end
        end
        ST_RESOLVE: begin
          bs_q    <= bs_d;
          sc_q    <= sc_d;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
          if (rise) rise_pend_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_waddr = waddr_q;
  assign rom_wdata = wdata_q;
  assign rom_size  = size_q;
  assign force_bs  = bs_q;
  assign sc        = sc_q;
  assign loading   = loading_q;
  assign done      = done_q;

endmodule

// File: doc/rom_loader_bs.md
Name: rom_loader_bs

Overview:
- Sits between the HPS ioctl download stream and the cartridge ROM dual-port RAM; A2601top consumes its outputs.
- Registers and forwards download bytes into the ROM RAM write port and tracks the loaded image size.
- At end of download, resolves the bank-switch scheme (force_bs) and the SuperChip enable (sc) from the file extension, the OSD SuperChip mode and, optionally, a content scan.
- Replaces the ad-hoc extension latch in the top level.

Parameters:
- AW, 15, ROM RAM address width (32 KB image max)
- SZW, 17, rom_size width
- SC_SCAN_LEN, 256, leading bytes examined by the SuperChip content heuristic

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ioctl_download  in  1  download active (level)
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_file_ext  in  32  file extension, ASCII, right-aligned
- sc_mode  in  2  0 auto, 1 disable, 2/3 enable
- rom_we  out  1  RAM write enable
- rom_waddr  out  AW  RAM write address
- rom_wdata  out  8  RAM write data
- rom_size  out  SZW  highest written address + 1
- force_bs  out  4  bank-switch code
- sc  out  1  SuperChip RAM enable
- loading  out  1  high in LOAD state
- done  out  1  one-cycle pulse when results are valid

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous.
- States:
  - IDLE: on rising edge of ioctl_download, go to LOAD.
  - LOAD: on falling edge of ioctl_download, go to RESOLVE.
  - RESOLVE: lasts one cycle, then returns to IDLE.
- Download edges are detected from a registered copy of ioctl_download.
- Entering LOAD, all in the same cycle:
  - Latch ext = (ioctl_file_ext[23:16]=="." ? ioctl_file_ext[23:0] : ioctl_file_ext[31:8]).
  - Latch S-flag = (ioctl_file_ext[7:0]=="S").
  - Clear rom_size, scan flags and the sig counter.
  - force_bs and sc hold their previous values until RESOLVE.
- LOAD write path:
  - Each ioctl_wr produces rom_we=1 exactly one cycle later.
  - rom_waddr = ioctl_addr[AW-1:0]; rom_wdata = ioctl_dout. Latency is 1.
  - Writes with ioctl_addr ≥ 2^AW are dropped (no rom_we) but still update rom_size.
  - rom_size = max(rom_size, ioctl_addr+1), saturating at 2^SZW−1.
  - ioctl_wr outside LOAD is ignored.
- RESOLVE, extension map: .F8→1, .F6→2, .FE→3, .E0→4, .3F→5, .F4→6, .P2→7, .FA→8, .CV→9, any other→0.
- RESOLVE, sc:
  - sc_mode 1 → 0; sc_mode 2/3 → 1.
  - sc_mode 0 → S-flag, OR'd with the content flag when scanning is compiled in.
- RESOLVE registers force_bs and sc, pulses done, and drops loading.
- Download falling edge while in IDLE (no preceding rise): ignored.
- A new rising edge during RESOLVE is taken next cycle from IDLE; no edge is lost because the edge register persists.
- reset_n low mid-LOAD: aborts, outputs cleared, no done pulse.

Optional Feature:
- Macro: BS_SIGSCAN_EN.
- Defined, content scan during LOAD:
  - scflag = all bytes at addresses < SC_SCAN_LEN equal the byte at address 0.
  - sig counter (3-bit, saturating) increments on each consecutive byte pair 0x85,0x3F (STA $3F).
- Defined, RESOLVE applies only when the extension maps to 0:
  - sig ≥ 2 and rom_size > 4096 → 5.
  - Else by size: 8192→1, 12288→8, 16384→2, 32768→6, otherwise 0.
- Not defined: extension map only; sc auto uses S-flag alone; no scan logic synthesised.

Decomposition:
- Package rom_loader_pkg holds:
  - the bs_e enum (NONE=0, F8, F6, FE, E0, 3F, F4, P2, FA, CV=9);
  - 24-bit ASCII extension constants;
  - the state enum;
  - the size constants.
- One sub-module, rom_sig_scan: SC flag and 0x85,0x3F pair counter. Instantiated only under BS_SIGSCAN_EN.

Test Plan:
- Reset with ioctl_download high → all outputs 0, no rom_we; after release with download still high, no LOAD until a fresh rising edge.
- ext ".F8", 8192 sequential writes → rom_we each write+1 cycle; rom_size=8192; force_bs=1; done pulses once.
- ext ".BIN", sc_mode 0, name ending "S" → sc=1; same with sc_mode 1 → sc=0; sc_mode 2 with ext "BIN" → sc=1.
- BS_SIGSCAN_EN, ext ".A26", 8192 bytes containing "85 3F" twice → force_bs=5; same without the pairs → 1; 12288 bytes → 8.
- BS_SIGSCAN_EN, sc_mode 0, first 256 bytes 0xFF → sc=1; byte 0x80=0x00 → sc=0.
- reset_n pulsed low at byte 100 of a load → outputs 0, no done; next full ".F6" 16384-byte load → force_bs=2, rom_size=16384.
